// File: rtl/writeback_buffer.sv
// Writeback FIFO in front of the 32x32 register file: queues ALU/load results,
// drains one per cycle into the write port and forwards queued values to decode.
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            result_valid,
  output logic            result_ready,
  input  logic [4:0]      result_reg,
  input  logic [31:0]     result_data,
  input  logic            hold,
  output logic [4:0]      write_register,
  output logic [31:0]     write_data,
  output logic            reg_write,
  input  logic [4:0]      read_register1,
  input  logic [4:0]      read_register2,
  output logic            bypass1_hit,
  output logic [31:0]     bypass1_data,
  output logic            bypass2_hit,
  output logic [31:0]     bypass2_data,
  output logic [PTRW:0]   count,
  output logic            empty
);

  localparam logic [PTRW:0] FULL = (PTRW + 1)'(DEPTH);

  logic [4:0]       ent_reg   [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [PTRW-1:0]  idx;
  logic             accept;
  logic             enqueue;

  // Ready looks only at registered occupancy, never at the same-cycle drain.
  assign result_ready   = (count != FULL);
  assign empty          = (count == '0);
  assign reg_write      = !empty && !hold;
  assign accept         = result_valid && result_ready;
  assign enqueue        = accept && (result_reg != 5'd0);
  assign write_register = empty ? 5'd0  : ent_reg[head];
  assign write_data     = empty ? 32'd0 : ent_data[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (enqueue) begin
        ent_reg[tail]   <= result_reg;
        ent_data[tail]  <= result_data;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (reg_write) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (enqueue && !reg_write) begin
        count <= count + 1'b1;
      end else if (!enqueue && reg_write) begin
        count <= count - 1'b1;
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    bypass1_hit  = 1'b0;
    bypass1_data = '0;
    bypass2_hit  = 1'b0;
    bypass2_data = '0;
    idx          = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTRW'(k);
      if (ent_valid[idx] && (ent_reg[idx] == read_register1) && (read_register1 != 5'd0)) begin
        bypass1_hit  = 1'b1;
        bypass1_data = ent_data[idx];
      end
      if (ent_valid[idx] && (ent_reg[idx] == read_register2) && (read_register2 != 5'd0)) begin
        bypass2_hit  = 1'b1;
        bypass2_data = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: a scoreboard queue of accepted results is checked
// against every drain, plus per-scenario tasks for reset, hold, bypass and streaming.
module tb_writeback_buffer;

  logic        clk;
  logic        rst;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  result_reg;
  logic [31:0] result_data;
  logic        hold;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        reg_write;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic        bypass1_hit;
  logic [31:0] bypass1_data;
  logic        bypass2_hit;
  logic [31:0] bypass2_data;
  logic [2:0]  count;
  logic        empty;

  int          checks;
  int          failures;
  int          writes;
  logic [36:0] sb [$];
  logic [31:0] rf [32];

  writeback_buffer #(.DEPTH(4), .PTRW(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_reg     (result_reg),
    .result_data    (result_data),
    .hold           (hold),
    .write_register (write_register),
    .write_data     (write_data),
    .reg_write      (reg_write),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .bypass1_hit    (bypass1_hit),
    .bypass1_data   (bypass1_data),
    .bypass2_hit    (bypass2_hit),
    .bypass2_data   (bypass2_data),
    .count          (count),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and register-file model, sampled 2 time units before each rising edge.
  always begin
    logic [36:0] exp_entry;
    logic        exp_write;
    @(negedge clk);
    #3;
    if (!rst) begin
      checks++;
      if (count !== 3'(sb.size())) begin
        failures++;
        $display("[TB] FAIL sb_count: got %0d, expected %0d", count, sb.size());
      end
      checks++;
      if (result_ready !== (sb.size() != 4)) begin
        failures++;
        $display("[TB] FAIL sb_ready: got %b, expected %b", result_ready, (sb.size() != 4));
      end
      exp_write = (sb.size() != 0) && !hold;
      checks++;
      if (reg_write !== exp_write) begin
        failures++;
        $display("[TB] FAIL sb_regwrite: got %b, expected %b", reg_write, exp_write);
      end
      if (reg_write === 1'b1 && sb.size() != 0) begin
        exp_entry = sb.pop_front();
        checks++;
        if ({write_register, write_data} !== exp_entry) begin
          failures++;
          $display("[TB] FAIL sb_write: got reg %0d data %0d, expected reg %0d data %0d",
                   write_register, write_data, exp_entry[36:32], exp_entry[31:0]);
        end
        rf[write_register] = write_data;
        writes++;
      end
      if (result_valid && result_ready && result_reg != 5'd0)
        sb.push_back({result_reg, result_data});
    end
  end

  // Tasks start and end 1 time unit after a falling edge.
  task automatic send(input logic [4:0] r, input logic [31:0] d, input int budget);
    bit taken;
    taken        = 1'b0;
    result_valid = 1'b1;
    result_reg   = r;
    result_data  = d;
    for (int i = 0; i < budget && !taken; i++) begin
      #1;
      if (result_ready) taken = 1'b1;
      @(negedge clk);
      #1;
    end
    checks++;
    if (!taken) begin
      failures++;
      $display("[TB] FAIL send_timeout: reg %0d not accepted, waited %0d cycles", r, budget);
    end
  endtask

  task automatic idle(input int n);
    result_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(input int budget);
    result_valid = 1'b0;
    for (int i = 0; i < budget && empty !== 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain_timeout: empty=%b count=%0d, expected empty=1", empty, count);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({count, result_ready, reg_write, empty} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_init: count=%0d ready=%b regwrite=%b empty=%b, expected 0 1 0 1",
               count, result_ready, reg_write, empty);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    hold = 1'b1;
    send(5'd7, 32'd1, 4);
    send(5'd8, 32'd2, 4);
    send(5'd9, 32'd3, 4);
    result_valid   = 1'b0;
    read_register1 = 5'd8;
    #1;
    checks++;
    if (bypass1_hit !== 1'b1 || count !== 3'd3) begin
      failures++;
      $display("[TB] FAIL reset_prefill: hit=%b count=%0d, expected 1 3", bypass1_hit, count);
    end
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({reg_write, count, result_ready, bypass1_hit, empty} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_async: regwrite=%b count=%0d ready=%b hit=%b empty=%b, expected 0 0 1 0 1",
               reg_write, count, result_ready, bypass1_hit, empty);
    end
    @(negedge clk);
    #1;
    rst  = 1'b0;
    hold = 1'b0;
    idle(3);
    checks++;
    if (writes !== 0) begin
      failures++;
      $display("[TB] FAIL reset_nowrite: %0d writes, expected 0", writes);
    end
  endtask

  task automatic test_single();
    hold = 1'b0;
    send(5'd2, 32'd42, 4);
    result_valid = 1'b0;
    checks++;
    if ({write_register, write_data, reg_write} !== {5'd2, 32'd42, 1'b1}) begin
      failures++;
      $display("[TB] FAIL single_port: reg=%0d data=%0d we=%b, expected 2 42 1",
               write_register, write_data, reg_write);
    end
    idle(1);
    checks++;
    if (empty !== 1'b1 || rf[2] !== 32'd42) begin
      failures++;
      $display("[TB] FAIL single_written: empty=%b rf2=%0d, expected 1 42", empty, rf[2]);
    end
  endtask

  task automatic test_hold_fill();
    hold = 1'b1;
    send(5'd5, 32'd10, 4);
    send(5'd5, 32'd11, 4);
    send(5'd7, 32'd12, 4);
    send(5'd9, 32'd13, 4);
    result_valid = 1'b1;
    result_reg   = 5'd3;
    result_data  = 32'd99;
    repeat (3) begin
      #1;
      checks++;
      if (count !== 3'd4 || result_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_full: count=%0d ready=%b, expected 4 0", count, result_ready);
      end
      @(negedge clk);
      #1;
    end
    read_register1 = 5'd5;
    #1;
    checks++;
    if (bypass1_hit !== 1'b1 || bypass1_data !== 32'd11) begin
      failures++;
      $display("[TB] FAIL hold_bypass: hit=%b data=%0d, expected 1 11", bypass1_hit, bypass1_data);
    end
    hold = 1'b0;
    send(5'd3, 32'd99, 6);
    wait_empty(10);
    checks++;
    if (rf[5] !== 32'd11 || rf[7] !== 32'd12 || rf[9] !== 32'd13 || rf[3] !== 32'd99) begin
      failures++;
      $display("[TB] FAIL hold_regs: r5=%0d r7=%0d r9=%0d r3=%0d, expected 11 12 13 99",
               rf[5], rf[7], rf[9], rf[3]);
    end
  endtask

  task automatic test_zero_reg();
    hold = 1'b0;
    read_register2 = 5'd0;
    send(5'd0, 32'd15, 4);
    result_valid = 1'b0;
    checks++;
    if ({count, empty, reg_write, bypass2_hit} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL zero_drop: count=%0d empty=%b we=%b hit2=%b, expected 0 1 0 0",
               count, empty, reg_write, bypass2_hit);
    end
  endtask

  task automatic test_stream();
    int start_writes;
    start_writes = writes;
    hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(5'(i + 1), 32'(100 + i), 4);
      checks++;
      if (count > 3'd1) begin
        failures++;
        $display("[TB] FAIL stream_count: beat %0d count=%0d, expected <= 1", i, count);
      end
    end
    wait_empty(4);
    checks++;
    if (writes - start_writes !== 10) begin
      failures++;
      $display("[TB] FAIL stream_writes: %0d writes, expected 10", writes - start_writes);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rf[i + 1] !== 32'(100 + i)) begin
        failures++;
        $display("[TB] FAIL stream_reg: r%0d=%0d, expected %0d", i + 1, rf[i + 1], 100 + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    hold = 1'b1;
    send(5'd11, 32'd500, 4);
    send(5'd12, 32'd501, 4);
    result_valid   = 1'b0;
    read_register1 = 5'd12;
    read_register2 = 5'd11;
    #1;
    checks++;
    if ({bypass2_hit, bypass2_data, bypass1_hit, bypass1_data} !== {1'b1, 32'd500, 1'b1, 32'd501}) begin
      failures++;
      $display("[TB] FAIL b2b_bypass: hit2=%b data2=%0d hit1=%b data1=%0d, expected 1 500 1 501",
               bypass2_hit, bypass2_data, bypass1_hit, bypass1_data);
    end
    hold = 1'b0;
    send(5'd13, 32'd502, 4);
    result_valid = 1'b0;
    checks++;
    if (count !== 3'd2 || bypass2_hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_count: count=%0d hit2=%b, expected 2 0", count, bypass2_hit);
    end
    wait_empty(6);
    checks++;
    if (rf[11] !== 32'd500 || rf[12] !== 32'd501 || rf[13] !== 32'd502) begin
      failures++;
      $display("[TB] FAIL b2b_regs: r11=%0d r12=%0d r13=%0d, expected 500 501 502",
               rf[11], rf[12], rf[13]);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    writes         = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst            = 1'b1;
    hold           = 1'b0;
    result_valid   = 1'b0;
    result_reg     = 5'd0;
    result_data    = 32'd0;
    read_register1 = 5'd0;
    read_register2 = 5'd0;
    #2;
    test_reset();
    test_single();
    test_hold_fill();
    test_zero_reg();
    test_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
